// File: rtl/bridge_leaf_regs_if.sv
// Bridge-side bus bundle for bridge_leaf_regs.
// Handshake: bridge_rd and bridge_wr are single-cycle strobes with no
// ready/backpressure; the leaf always accepts. bridge_rd_data becomes valid
// a fixed RD_LATENCY cycles after bridge_rd and holds until the next read
// completes.
interface bridge_leaf_regs_if;
    logic [31:0] bridge_addr;
    logic        bridge_rd;
    logic        bridge_wr;
    logic [31:0] bridge_wr_data;
    logic [31:0] bridge_rd_data;

    modport master (
        output bridge_addr,
        output bridge_rd,
        output bridge_wr,
        output bridge_wr_data,
        input  bridge_rd_data
    );

    modport slave (
        input  bridge_addr,
        input  bridge_rd,
        input  bridge_wr,
        input  bridge_wr_data,
        output bridge_rd_data
    );
endinterface

// File: rtl/bridge_leaf_regs.sv
// Register-file leaf on the bridge bus: NUM_RO read-only status words at the
// low indices mirror status_in, the rest are RW registers writable from the
// bridge (with a per-register strobe) and from the core (bridge wins on a
// same-index collision). Reads complete after a fixed RD_LATENCY.
// Optional macro BRIDGE_LEAF_REGS_BYTESWAP_EN byte-reverses bridge write data
// before storage and bridge read data on output; core ports never swap.
module bridge_leaf_regs #(
    parameter int          NUM_REGS    = 16,
    parameter int          NUM_RO      = 4,
    parameter int          RD_LATENCY  = 2,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    localparam int         IDX_W       = $clog2(NUM_REGS),
    localparam int         RO_W        = (NUM_RO == 0) ? 1 : NUM_RO
) (
    input  logic                      clk_74a,
    input  logic                      reset,
    bridge_leaf_regs_if.slave         bus,
    input  logic [32*RO_W-1:0]        status_in,
    output logic [32*NUM_REGS-1:0]    regs_q,
    output logic [NUM_REGS-1:0]       reg_wr_stb,
    input  logic                      core_wr,
    input  logic [IDX_W-1:0]          core_wr_idx,
    input  logic [31:0]               core_wr_data,
    output logic                      core_wr_lost
);
    // Depth of the registered part of the read pipeline; the final stage is
    // the bridge_rd_data holding register itself.
    localparam int PD = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;

    function automatic logic [31:0] swap_bytes(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    logic [31:0]         rw_q [NUM_REGS];
    logic [31:0]         rw_d [NUM_REGS];
    logic [31:0]         cur_word [NUM_REGS];
    logic [NUM_REGS-1:0] reg_wr_stb_q, reg_wr_stb_d;
    logic                core_wr_lost_q, core_wr_lost_d;
    logic [PD-1:0]       pv_q, pv_d;
    logic [31:0]         pd_q [PD];
    logic [31:0]         pd_d [PD];
    logic [31:0]         rd_data_q, rd_data_d;

    logic [IDX_W-1:0]    b_idx;
    logic                b_in_range;
    logic                b_wr_ok;
    logic                c_wr_drop;
    logic [31:0]         wr_word;
    logic [31:0]         rd_word;
    logic                done_v;
    logic [31:0]         done_data;
    logic                unused_addr_lsbs;

    assign b_idx            = bus.bridge_addr[IDX_W+1:2];
    assign b_in_range       = (bus.bridge_addr[31:IDX_W+2] == '0);
    assign unused_addr_lsbs = ^bus.bridge_addr[1:0];

    // Current view of every slot: RO slots follow status_in live.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_view
        if (i < NUM_RO) begin : g_ro
            assign cur_word[i] = status_in[32*i +: 32];
        end else begin : g_rw
            assign cur_word[i] = rw_q[i];
        end
        assign regs_q[32*i +: 32] = cur_word[i];
    end

    // Data conversion between bridge byte order and storage order.
    always_comb begin
`ifdef BRIDGE_LEAF_REGS_BYTESWAP_EN
        wr_word = swap_bytes(bus.bridge_wr_data);
        rd_word = b_in_range ? swap_bytes(cur_word[b_idx]) : 32'h0;
`else
        wr_word = bus.bridge_wr_data;
        rd_word = b_in_range ? cur_word[b_idx] : 32'h0;
`endif
    end

    // Write arbitration: bridge writes to RW slots, core writes yield on collision.
    always_comb begin
        b_wr_ok   = bus.bridge_wr && b_in_range && (int'(b_idx) >= NUM_RO);
        c_wr_drop = core_wr && ((int'(core_wr_idx) < NUM_RO) ||
                                (b_wr_ok && (core_wr_idx == b_idx)));
        for (int i = 0; i < NUM_REGS; i++) rw_d[i] = rw_q[i];
        if (core_wr && !c_wr_drop) rw_d[core_wr_idx] = core_wr_data;
        if (b_wr_ok) rw_d[b_idx] = wr_word;
        reg_wr_stb_d = '0;
        if (b_wr_ok) reg_wr_stb_d[b_idx] = 1'b1;
        core_wr_lost_d = c_wr_drop;
    end

    // Read pipeline: data is captured on the bridge_rd cycle (pre-write value,
    // status sampled then) and shifted along with its valid bit.
    always_comb begin
        pv_d = '0;
        for (int k = 0; k < PD; k++) pd_d[k] = pd_q[k];
        pv_d[0] = bus.bridge_rd;
        pd_d[0] = rd_word;
        for (int k = 1; k < PD; k++) begin
            pv_d[k] = pv_q[k-1];
            pd_d[k] = pd_q[k-1];
        end
        if (RD_LATENCY == 1) begin
            done_v    = bus.bridge_rd;
            done_data = rd_word;
        end else begin
            done_v    = pv_q[PD-1];
            done_data = pd_q[PD-1];
        end
        rd_data_d = done_v ? done_data : rd_data_q;
    end

    // State registers; reset also drops any read in flight.
    always_ff @(posedge clk_74a or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) rw_q[i] <= RESET_VALUE;
            for (int k = 0; k < PD; k++) pd_q[k] <= 32'h0;
            pv_q           <= '0;
            rd_data_q      <= 32'h0;
            reg_wr_stb_q   <= '0;
            core_wr_lost_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) rw_q[i] <= rw_d[i];
            for (int k = 0; k < PD; k++) pd_q[k] <= pd_d[k];
            pv_q           <= pv_d;
            rd_data_q      <= rd_data_d;
            reg_wr_stb_q   <= reg_wr_stb_d;
            core_wr_lost_q <= core_wr_lost_d;
        end
    end

    assign bus.bridge_rd_data = rd_data_q;
    assign reg_wr_stb         = reg_wr_stb_q;
    assign core_wr_lost       = core_wr_lost_q;
endmodule

// File: tb/tb_bridge_leaf_regs.sv
// Bench for bridge_leaf_regs: directed scenarios followed by random traffic,
// all checked every cycle against a word-array reference model.
module tb_bridge_leaf_regs;
    localparam int          NR  = 16;
    localparam int          NRO = 4;
    localparam int          LAT = 2;
    localparam int          AW  = 4;
    localparam logic [31:0] RV  = 32'hA5A5_0000;

    // ---------------- clock / reset ----------------
    logic clk_74a = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_74a = ~clk_74a;

    bridge_leaf_regs_if bus ();
    logic [32*NRO-1:0] status_in;
    logic [32*NR-1:0]  regs_q;
    logic [NR-1:0]     reg_wr_stb;
    logic              core_wr;
    logic [AW-1:0]     core_wr_idx;
    logic [31:0]       core_wr_data;
    logic              core_wr_lost;

    bridge_leaf_regs #(
        .NUM_REGS(NR), .NUM_RO(NRO), .RD_LATENCY(LAT), .RESET_VALUE(RV)
    ) dut (
        .clk_74a(clk_74a), .reset(reset), .bus(bus.slave),
        .status_in(status_in), .regs_q(regs_q), .reg_wr_stb(reg_wr_stb),
        .core_wr(core_wr), .core_wr_idx(core_wr_idx), .core_wr_data(core_wr_data),
        .core_wr_lost(core_wr_lost)
    );

    // ---------------- reference model ----------------
    logic [31:0] mem [NR];
    logic [31:0] exp_q [$];
    int          due_q [$];
    logic [31:0] exp_rd;
    logic [31:0] exp_stb;
    logic        exp_lost;
    int          cyc;
    int          errors;
    int          checks;

    function automatic logic [31:0] swap32(input logic [31:0] w);
`ifdef BRIDGE_LEAF_REGS_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mem[i] = RV;
        exp_q.delete();
        due_q.delete();
        exp_rd   = 32'h0;
        exp_stb  = 32'h0;
        exp_lost = 1'b0;
    endtask

    // One clock edge of the specified behaviour, from the inputs now driven.
    task automatic model_step();
        int          word, bidx;
        logic        in_rng, wok;
        logic [31:0] val;
        word   = int'(bus.bridge_addr >> 2);
        in_rng = (bus.bridge_addr >> 2) < NR;
        bidx   = word % NR;
        if (bus.bridge_rd) begin
            if (!in_rng)         val = 32'h0;
            else if (bidx < NRO) val = status_in[32*bidx +: 32];
            else                 val = mem[bidx];
            exp_q.push_back(swap32(val));
            due_q.push_back(cyc + LAT - 1);
        end
        wok      = bus.bridge_wr && in_rng && (bidx >= NRO);
        exp_lost = core_wr && ((int'(core_wr_idx) < NRO) || (wok && int'(core_wr_idx) == bidx));
        if (core_wr && !exp_lost) mem[core_wr_idx] = core_wr_data;
        exp_stb = 32'h0;
        if (wok) begin
            mem[bidx] = swap32(bus.bridge_wr_data);
            exp_stb   = 32'h1 << bidx;
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            exp_rd = exp_q.pop_front();
            void'(due_q.pop_front());
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_outputs();
        check("rd_data", bus.bridge_rd_data, exp_rd);
        check("wr_stb", 32'(reg_wr_stb), exp_stb);
        check("core_lost", 32'(core_wr_lost), 32'(exp_lost));
        for (int i = 0; i < NR; i++) begin
            if (i < NRO) check($sformatf("regs_q[%0d]", i), regs_q[32*i +: 32], status_in[32*i +: 32]);
            else         check($sformatf("regs_q[%0d]", i), regs_q[32*i +: 32], mem[i]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic cw,
                         input logic [AW-1:0] cidx, input logic [31:0] cdata);
        bus.bridge_rd      = rd;
        bus.bridge_wr      = wr;
        bus.bridge_addr    = addr;
        bus.bridge_wr_data = wdata;
        core_wr            = cw;
        core_wr_idx        = cidx;
        core_wr_data       = cdata;
        @(posedge clk_74a);
        cyc++;
        model_step();
        @(negedge clk_74a);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, '0, 32'h0);
    endtask

    task automatic apply_reset();
        bus.bridge_rd = 1'b0;
        bus.bridge_wr = 1'b0;
        core_wr       = 1'b0;
        reset         = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk_74a);
        @(negedge clk_74a);
        check_outputs();
        reset = 1'b0;
    endtask

    task automatic randomize_status();
        for (int i = 0; i < NRO; i++) status_in[32*i +: 32] = $urandom;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        bus.bridge_addr    = 32'h0;
        bus.bridge_wr_data = 32'h0;
        core_wr_idx        = '0;
        core_wr_data       = 32'h0;
        status_in          = '0;
        @(negedge clk_74a);
        apply_reset();

        // Write then read an RW register.
        cycle(1'b0, 1'b1, 32'h14, 32'h1122_3344, 1'b0, '0, 32'h0);
        idle(2);
        cycle(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, '0, 32'h0);
        idle(3);

        // Write to an RO slot is ignored; read returns the status word.
        status_in[32*1 +: 32] = 32'hCAFE_0001;
        cycle(1'b0, 1'b1, 32'h04, 32'hDEAD_BEEF, 1'b0, '0, 32'h0);
        cycle(1'b1, 1'b0, 32'h04, 32'h0, 1'b0, '0, 32'h0);
        idle(3);

        // Back-to-back reads of 4, 6, 7.
        cycle(1'b0, 1'b1, 32'h10, 32'h4444_0004, 1'b0, '0, 32'h0);
        cycle(1'b0, 1'b1, 32'h18, 32'h6666_0006, 1'b0, '0, 32'h0);
        cycle(1'b0, 1'b1, 32'h1C, 32'h7777_0007, 1'b0, '0, 32'h0);
        cycle(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, '0, 32'h0);
        cycle(1'b1, 1'b0, 32'h18, 32'h0, 1'b0, '0, 32'h0);
        cycle(1'b1, 1'b0, 32'h1C, 32'h0, 1'b0, '0, 32'h0);
        idle(3);

        // Bridge and core write index 8 in the same cycle: bridge wins.
        cycle(1'b0, 1'b1, 32'h20, 32'hA, 1'b1, 4'd8, 32'hB);
        idle(2);
        // Core write to RO slot is dropped; core write to RW slot lands.
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd2, 32'h1234);
        cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 4'd12, 32'h5678);
        idle(2);

        // Out-of-range read and write.
        cycle(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, '0, 32'h0);
        cycle(1'b0, 1'b1, 32'h124, 32'hFFFF_FFFF, 1'b0, '0, 32'h0);
        idle(3);

        // Simultaneous read and write of index 9 returns the old value.
        cycle(1'b0, 1'b1, 32'h24, 32'h1, 1'b0, '0, 32'h0);
        cycle(1'b1, 1'b1, 32'h24, 32'h2, 1'b0, '0, 32'h0);
        idle(3);

        // Reset one cycle after a read: the read is discarded.
        cycle(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, '0, 32'h0);
        apply_reset();
        idle(LAT + 2);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            int          word;
            logic [31:0] addr;
            randomize_status();
            word = ($urandom_range(0, 9) == 0) ? $urandom_range(NR, 300) : $urandom_range(0, NR - 1);
            addr = 32'(word * 4 + $urandom_range(0, 3));
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), addr, $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), $urandom);
            if ($urandom_range(0, 199) == 0) apply_reset();
        end
        idle(LAT + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
